pipeline_hazard_controller: RTL and testbench

Sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). Each cycle it takes the decoded ID-stage instruction and the EX-stage state, then drives stall, flush and bubble controls into the PC and the IF/ID and ID/EX pipeline registers. It handles load-use hazards, taken-branch flushes, and the EBREAK / illegal-instruction drain-to-halt sequence. It also keeps stall and flush performance counters.

---
 rtl/pipeline_hazard_controller_pkg.sv | 31 +++
 rtl/pipeline_hazard_controller_if.sv | 43 ++++
 rtl/pipeline_hazard_controller_load_use_detector.sv | 33 +++
 rtl/pipeline_hazard_controller.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller_pkg
// Purpose  : Shared types for the 5-stage pipeline hazard controller:
//            controller state encoding, default drain length and the
//            stall/flush/bubble control bundle consumed by the PC and the
//            IF/ID and ID/EX pipeline registers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    HS_RUN    = 2'd0,
    HS_DRAIN  = 2'd1,
    HS_HALTED = 2'd2
  } HazardState;

  // Cycles from ID-stage EBREAK/illegal acceptance until every older
  // instruction has retired out of WB.
  localparam int DEFAULT_DRAIN_CYCLES = 3;

  typedef struct packed {
    logic pc_stall;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_bubble;
  } HazardCtrl;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller_if
// Purpose  : Bundle between the pipeline datapath and the hazard controller.
// Ports    : master - pipeline side: drives ID/EX status, receives controls
//            slave  - controller side: reads ID/EX status, drives controls
//            Signals: id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
//            id_is_ebreak, id_invalid, ex_valid, ex_is_load, ex_rd,
//            ex_branch_taken, ctrl (HazardCtrl)
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_controller_if;
  import pipeline_hazard_controller_pkg::*;

  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       id_is_ebreak;
  logic       id_invalid;
  logic       ex_valid;
  logic       ex_is_load;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  HazardCtrl  ctrl;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_is_ebreak, id_invalid, ex_valid, ex_is_load, ex_rd,
           ex_branch_taken,
    input  ctrl
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_is_ebreak, id_invalid, ex_valid, ex_is_load, ex_rd,
           ex_branch_taken,
    output ctrl
  );

endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detector
// Purpose  : Combinational load-use hazard comparator: the instruction in ID
//            reads a register that the load currently in EX has not yet
//            produced. x0 never creates a hazard.
// Ports    : ex_valid, ex_is_load, ex_rd      - EX-stage producer
//            id_valid, id_rs1/2, id_uses_rs1/2 - ID-stage consumer
//            luh                              - hazard present
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detector (
  input  wire logic       ex_valid,
  input  wire logic       ex_is_load,
  input  wire logic [4:0] ex_rd,
  input  wire logic       id_valid,
  input  wire logic [4:0] id_rs1,
  input  wire logic [4:0] id_rs2,
  input  wire logic       id_uses_rs1,
  input  wire logic       id_uses_rs2,
  output logic            luh
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign luh     = ex_valid && ex_is_load && id_valid && (ex_rd != 5'd0) &&
                   (rs1_hit || rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : Stall/flush/bubble sequencing for the 5-stage pipeline:
//            load-use stalls, taken-branch flushes and the EBREAK/illegal
//            drain-to-halt sequence, with saturating performance counters.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            hz (slave)          - ID/EX status in, HazardCtrl out (comb)
//            halted, trap        - registered halt status
//            stall_count         - load-use stall cycles (saturating)
//            flush_count         - redirect flushes (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int CNT_W        = 32
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  pipeline_hazard_controller_if.slave hz,
  output logic                       halted,
  output logic                       trap,
  output logic [CNT_W-1:0]           stall_count,
  output logic [CNT_W-1:0]           flush_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  HazardState     state;
  logic [DW-1:0]  drain_cnt;
  logic           trap_pending;
  logic           luh;
  logic           halt_req;
  HazardCtrl      ctrl;

  load_use_detector u_luh (
    .ex_valid    (hz.ex_valid),
    .ex_is_load  (hz.ex_is_load),
    .ex_rd       (hz.ex_rd),
    .id_valid    (hz.id_valid),
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .id_uses_rs1 (hz.id_uses_rs1),
    .id_uses_rs2 (hz.id_uses_rs2),
    .luh         (luh)
  );

  assign halt_req = hz.id_valid && (hz.id_is_ebreak || hz.id_invalid);

  // Controls are combinational so the pipeline registers react in the same
  // cycle the hazard is seen. Priority in RUN: branch, load-use, halt.
  always_comb begin
    ctrl = '0;
    case (state)
      HS_RUN: begin
        if (hz.ex_branch_taken) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end else if (luh) begin
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_hold   = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end else if (halt_req) begin
          // The EBREAK/illegal itself enters EX as the decoder's NOP.
          ctrl.pc_stall    = 1'b1;
          ctrl.if_id_flush = 1'b1;
        end
      end
      HS_DRAIN: begin
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_bubble = hz.ex_branch_taken;
      end
      HS_HALTED: begin
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_bubble = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign hz.ctrl = ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HS_RUN;
      drain_cnt    <= '0;
      trap_pending <= 1'b0;
      halted       <= 1'b0;
      trap         <= 1'b0;
      stall_count  <= '0;
      flush_count  <= '0;
    end else begin
      case (state)
        HS_RUN: begin
          if (hz.ex_branch_taken) begin
            if (!(&flush_count)) flush_count <= flush_count + CNT_W'(1);
          end else if (luh) begin
            if (!(&stall_count)) stall_count <= stall_count + CNT_W'(1);
          end else if (halt_req) begin
            trap_pending <= hz.id_invalid;
            drain_cnt    <= DW'(DRAIN_CYCLES - 1);
            state        <= HS_DRAIN;
          end
        end
        HS_DRAIN: begin
          if (hz.ex_branch_taken) begin
            // An older instruction redirected: the halt was speculative.
            state        <= HS_RUN;
            trap_pending <= 1'b0;
            if (!(&flush_count)) flush_count <= flush_count + CNT_W'(1);
          end else if (drain_cnt == '0) begin
            state  <= HS_HALTED;
            halted <= 1'b1;
            trap   <= trap_pending;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        HS_HALTED: begin
          state <= HS_HALTED;
        end
        default: state <= HS_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Purpose  : Self-checking bench for pipeline_hazard_controller: a cycle
//            model compared every cycle plus directed literal expectations.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  localparam int DRAIN = 3;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          halted;
  logic          trap;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;

  pipeline_hazard_controller_if hz ();

  pipeline_hazard_controller #(
    .DRAIN_CYCLES (DRAIN),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hz          (hz),
    .halted      (halted),
    .trap        (trap),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_stall, m_flush, cyc, halt_at;
  bit m_drain, m_halted, m_trap, m_pend;

  function automatic bit model_luh();
    if (!(hz.ex_valid && hz.ex_is_load && hz.id_valid) || hz.ex_rd == 0) return 1'b0;
    return (hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) ||
           (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd);
  endfunction

  // {pc_stall, if_id_hold, if_id_flush, id_ex_bubble}
  function automatic logic [3:0] model_ctrl();
    if (m_halted) return 4'b1011;
    if (m_drain)  return {1'b1, 1'b0, 1'b1, hz.ex_branch_taken};
    if (hz.ex_branch_taken) return 4'b0011;
    if (model_luh()) return 4'b1101;
    if (hz.id_valid && (hz.id_is_ebreak || hz.id_invalid)) return 4'b1010;
    return 4'b0000;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < SAT) ? v + 1 : SAT;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_stall = 0; m_flush = 0; cyc = 0; halt_at = 0;
      m_drain = 0; m_halted = 0; m_trap = 0; m_pend = 0;
    end else begin
      if (!m_halted) begin
        if (m_drain) begin
          if (hz.ex_branch_taken) begin
            m_drain = 0; m_pend = 0; m_flush = sat_inc(m_flush);
          end
        end else if (hz.ex_branch_taken) begin
          m_flush = sat_inc(m_flush);
        end else if (model_luh()) begin
          m_stall = sat_inc(m_stall);
        end else if (hz.id_valid && (hz.id_is_ebreak || hz.id_invalid)) begin
          m_drain = 1; m_pend = hz.id_invalid; halt_at = cyc + 1 + DRAIN;
        end
      end
      cyc++;
      if (m_drain && cyc >= halt_at) begin
        m_drain = 0; m_halted = 1; m_trap = m_pend;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [3:0] e;
    if (!reset) begin
      e = model_ctrl();
      chk("pc_stall",     int'(hz.ctrl.pc_stall),     int'(e[3]));
      chk("if_id_hold",   int'(hz.ctrl.if_id_hold),   int'(e[2]));
      chk("if_id_flush",  int'(hz.ctrl.if_id_flush),  int'(e[1]));
      chk("id_ex_bubble", int'(hz.ctrl.id_ex_bubble), int'(e[0]));
      chk("halted",       int'(halted),               int'(m_halted));
      chk("trap",         int'(trap),                 int'(m_trap));
      chk("stall_count",  int'(stall_count),          m_stall);
      chk("flush_count",  int'(flush_count),          m_flush);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs2 = 0;
    hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
    hz.id_is_ebreak = 0; hz.id_invalid = 0;
    hz.ex_valid = 0; hz.ex_is_load = 0; hz.ex_rd = 0;
    hz.ex_branch_taken = 0;
  endtask

  task automatic set_luh(input logic [4:0] rd);
    hz.ex_valid = 1; hz.ex_is_load = 1; hz.ex_rd = rd;
    hz.id_valid = 1; hz.id_rs1 = rd; hz.id_uses_rs1 = 1;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) tick();
    reset = 0;
    chk("rst_halted", int'(halted), 0);
    chk("rst_trap", int'(trap), 0);
    chk("rst_stall_count", int'(stall_count), 0);
    chk("rst_flush_count", int'(flush_count), 0);

    // lw x5 in EX, add x6,x5,x1 in ID
    hz.ex_valid = 1; hz.ex_is_load = 1; hz.ex_rd = 5;
    hz.id_valid = 1; hz.id_rs1 = 5; hz.id_uses_rs1 = 1; hz.id_rs2 = 1; hz.id_uses_rs2 = 1;
    #1 chk("luh_ctrl", int'(hz.ctrl), 4'b1101);
    tick();
    chk("luh_stall_count", int'(stall_count), 1);
    hz.ex_valid = 0;  // bubble now in EX
    #1 chk("luh_resolved_ctrl", int'(hz.ctrl), 0);
    tick();
    chk("luh_one_cycle", int'(stall_count), 1);

    // destination x0 never stalls
    hz.ex_valid = 1; hz.ex_rd = 0; hz.id_rs1 = 0;
    #1 chk("x0_no_stall", int'(hz.ctrl), 0);
    tick();

    // rs2 hazard, then same register with rs2 unused
    idle(); hz.ex_valid = 1; hz.ex_is_load = 1; hz.ex_rd = 7;
    hz.id_valid = 1; hz.id_rs1 = 3; hz.id_uses_rs1 = 1; hz.id_rs2 = 7; hz.id_uses_rs2 = 1;
    tick();
    chk("rs2_stall_count", int'(stall_count), 2);
    hz.id_uses_rs2 = 0;
    tick();
    chk("rs2_unused", int'(stall_count), 2);

    // taken branch
    idle(); hz.ex_branch_taken = 1;
    #1 chk("br_ctrl", int'(hz.ctrl), 4'b0011);
    tick();
    chk("br_flush_count", int'(flush_count), 1);
    // branch together with load-use: flush only
    set_luh(9); hz.ex_branch_taken = 1;
    #1 chk("br_luh_ctrl", int'(hz.ctrl), 4'b0011);
    tick();
    chk("br_luh_stall", int'(stall_count), 2);
    chk("br_luh_flush", int'(flush_count), 2);

    // EBREAK drain to halt
    idle(); hz.id_valid = 1; hz.id_is_ebreak = 1;
    #1 chk("ebreak_ctrl", int'(hz.ctrl), 4'b1010);
    tick(); idle();
    tick(); tick();
    chk("drain_not_halted", int'(halted), 0);
    tick();
    chk("ebreak_halted", int'(halted), 1);
    chk("ebreak_trap", int'(trap), 0);
    set_luh(4); hz.ex_branch_taken = 1;
    repeat (5) tick();
    chk("halted_ignore_stall", int'(stall_count), 2);
    chk("halted_ignore_flush", int'(flush_count), 2);
    idle();
    do_reset();
    chk("halt_reset_halted", int'(halted), 0);
    chk("halt_reset_stall", int'(stall_count), 0);
    #1 chk("halt_reset_ctrl", int'(hz.ctrl), 0);

    // illegal instruction
    hz.id_valid = 1; hz.id_invalid = 1;
    tick(); idle();
    repeat (3) tick();
    chk("illegal_halted", int'(halted), 1);
    chk("illegal_trap", int'(trap), 1);
    do_reset();

    // speculative EBREAK cancelled in first drain cycle
    hz.id_valid = 1; hz.id_is_ebreak = 1;
    tick(); idle(); hz.ex_branch_taken = 1;
    #1 chk("spec_ctrl", int'(hz.ctrl), 4'b1011);
    tick(); idle();
    repeat (6) tick();
    chk("spec_not_halted", int'(halted), 0);
    chk("spec_flush", int'(flush_count), 1);

    // branch together with EBREAK stays in RUN
    hz.ex_branch_taken = 1; hz.id_valid = 1; hz.id_is_ebreak = 1;
    tick(); idle();
    #1 chk("br_ebreak_run", int'(hz.ctrl), 0);
    repeat (5) tick();
    chk("br_ebreak_not_halted", int'(halted), 0);
    chk("br_ebreak_flush", int'(flush_count), 2);

    // saturation
    set_luh(12);
    repeat (SAT + 4) tick();
    chk("stall_saturated", int'(stall_count), SAT);
    idle(); hz.ex_branch_taken = 1;
    repeat (SAT + 2) tick();
    chk("flush_saturated", int'(flush_count), SAT);

    // reset in the middle of a drain
    idle(); hz.id_valid = 1; hz.id_is_ebreak = 1;
    tick(); idle(); tick();
    do_reset();
    #1 chk("mid_drain_reset_ctrl", int'(hz.ctrl), 0);
    repeat (6) tick();
    chk("mid_drain_reset_halted", int'(halted), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
